midi_voice_alloc: RTL and testbench

Parametrised polyphonic successor to the two-channel fixed note/velocity latch. It sits directly after the MIDI byte parser and accepts its note events. It assigns each event on a configurable set of MIDI channels to one of NUM_VOICES synth voices, using retrigger, free-voice and least-recently-used stealing rules. It drives per-voice note, velocity, gate and trigger outputs to the oscillator/envelope bank.

---
 rtl/midi_voice_alloc_if.sv | 29 ++
 rtl/midi_voice_alloc.sv | 102 ++++++++++
 tb/tb_midi_voice_alloc.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/midi_voice_alloc_if.sv
// Event bus from the MIDI parser into the voice allocator, plus the
// per-voice control bus out to the oscillator/envelope bank.
interface midi_voice_alloc_if #(
  parameter int NUM_VOICES = 4
);
  logic                      ev_valid;
  logic                      ev_on;
  logic [6:0]                ev_note;
  logic [7:0]                ev_vel;
  logic [3:0]                ev_chan;
  logic                      panic;
  logic [8*NUM_VOICES-1:0]   voice_note;
  logic [8*NUM_VOICES-1:0]   voice_vel;
  logic [NUM_VOICES-1:0]     voice_gate;
  logic [NUM_VOICES-1:0]     voice_trig;
  logic                      drop;

  // Parser / driver side
  modport master (
    output ev_valid, ev_on, ev_note, ev_vel, ev_chan, panic,
    input  voice_note, voice_vel, voice_gate, voice_trig, drop
  );

  // Allocator side
  modport slave (
    input  ev_valid, ev_on, ev_note, ev_vel, ev_chan, panic,
    output voice_note, voice_vel, voice_gate, voice_trig, drop
  );
endinterface

// File: rtl/midi_voice_alloc.sv
// Polyphonic MIDI voice allocator: retrigger, free-voice, then LRU steal
// (or drop). One-cycle latency, one event per cycle, no backpressure.
module midi_voice_alloc #(
  parameter int          NUM_VOICES = 4,
  parameter logic [15:0] CHAN_MASK  = 16'h0001,
  parameter logic [7:0]  FIXED_VEL  = 8'd0,
  parameter bit          STEAL_EN   = 1'b1
) (
  input logic               clk_50m,
  input logic               rst,
  midi_voice_alloc_if.slave bus
);
  localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  typedef logic [AW-1:0] age_t;
  localparam age_t AGE_LRU = age_t'(NUM_VOICES - 1);

  logic [NUM_VOICES-1:0][6:0] note_q;
  logic [NUM_VOICES-1:0][7:0] vel_q;
  age_t [NUM_VOICES-1:0]      age_q;
  logic [NUM_VOICES-1:0]      gate_q;
  logic [NUM_VOICES-1:0]      trig_q;
  logic                       drop_q;

  logic                  qual, note_on, alloc;
  logic [NUM_VOICES-1:0] hit;
  logic                  hit_any, free_any;
  age_t                  hit_idx, free_idx, lru_idx, tgt, tgt_age;
  logic [7:0]            new_vel;

  // Target search: three priority encoders feeding a fixed rule order
  always_comb begin
    qual     = bus.ev_valid && CHAN_MASK[bus.ev_chan];
    note_on  = bus.ev_on && (bus.ev_vel != 8'd0);
    hit      = '0;
    hit_any  = 1'b0;
    free_any = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    lru_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      hit[i] = gate_q[i] && (note_q[i] == bus.ev_note);
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = age_t'(i);
      end
      if (!gate_q[i]) begin
        free_any = 1'b1;
        free_idx = age_t'(i);
      end
      if (age_q[i] == AGE_LRU) lru_idx = age_t'(i);
    end
    tgt     = hit_any ? hit_idx : (free_any ? free_idx : lru_idx);
    alloc   = hit_any || free_any || STEAL_EN;
    tgt_age = age_q[tgt];
    new_vel = (FIXED_VEL != 8'd0) ? FIXED_VEL : bus.ev_vel;
  end

  // Voice state update: reset > panic > qualified event
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      note_q <= '0;
      vel_q  <= '0;
      gate_q <= '0;
      trig_q <= '0;
      drop_q <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= age_t'(i);
    end else begin
      trig_q <= '0;
      drop_q <= 1'b0;
      if (bus.panic) begin
        gate_q <= '0;
      end else if (qual) begin
        if (note_on) begin
          if (alloc) begin
            note_q[tgt] <= bus.ev_note;
            vel_q[tgt]  <= new_vel;
            gate_q[tgt] <= 1'b1;
            trig_q[tgt] <= 1'b1;
            // Target becomes newest; everything younger than it ages by one
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (age_t'(i) == tgt)       age_q[i] <= '0;
              else if (age_q[i] < tgt_age) age_q[i] <= age_q[i] + age_t'(1);
            end
          end else begin
            drop_q <= 1'b1;
          end
        end else begin
          // Note, vel and age stay so the release keeps its pitch
          gate_q <= gate_q & ~hit;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_out
    assign bus.voice_note[8*i +: 8] = {1'b0, note_q[i]};
    assign bus.voice_vel[8*i +: 8]  = vel_q[i];
  end
  assign bus.voice_gate = gate_q;
  assign bus.voice_trig = trig_q;
  assign bus.drop       = drop_q;
endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench: two allocators (stealing / dropping) share one stimulus
// stream; a recency-timestamp model predicts every cycle's outputs.
module tb_midi_voice_alloc;
  localparam int          NV   = 4;
  localparam logic [15:0] MASK = 16'h0003;

  logic clk_50m = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_50m = ~clk_50m;

  midi_voice_alloc_if #(.NUM_VOICES(NV)) ifa ();
  midi_voice_alloc_if #(.NUM_VOICES(NV)) ifb ();

  midi_voice_alloc #(.NUM_VOICES(NV), .CHAN_MASK(MASK), .FIXED_VEL(8'd0), .STEAL_EN(1'b1))
    dut_a (.clk_50m(clk_50m), .rst(rst), .bus(ifa.slave));
  midi_voice_alloc #(.NUM_VOICES(NV), .CHAN_MASK(MASK), .FIXED_VEL(8'd0), .STEAL_EN(1'b0))
    dut_b (.clk_50m(clk_50m), .rst(rst), .bus(ifb.slave));

  typedef struct packed {
    logic [31:0] n0, v0; logic [3:0] g0, t0; logic d0;
    logic [31:0] n1, v1; logic [3:0] g1, t1; logic d1;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  // Model: each voice remembers when it was last allocated; LRU = oldest stamp
  int m_note [2][NV];
  int m_vel  [2][NV];
  bit m_gate [2][NV];
  bit m_trig [2][NV];
  int m_stamp[2][NV];
  bit m_drop [2];
  int now = 0;

  task automatic model(int m, bit r, bit pn, bit v, bit on, int note, int vel, int ch);
    int tgt;
    for (int i = 0; i < NV; i++) m_trig[m][i] = 0;
    m_drop[m] = 0;
    if (r) begin
      for (int i = 0; i < NV; i++) begin
        m_note[m][i] = 0; m_vel[m][i] = 0; m_gate[m][i] = 0; m_stamp[m][i] = -i;
      end
    end else if (pn) begin
      for (int i = 0; i < NV; i++) m_gate[m][i] = 0;
    end else if (v && MASK[ch]) begin
      if (on && vel != 0) begin
        tgt = -1;
        for (int i = 0; i < NV; i++) if (tgt < 0 && m_gate[m][i] && m_note[m][i] == note) tgt = i;
        for (int i = 0; i < NV; i++) if (tgt < 0 && !m_gate[m][i]) tgt = i;
        if (tgt < 0 && m == 0) begin
          tgt = 0;
          for (int i = 1; i < NV; i++) if (m_stamp[m][i] < m_stamp[m][tgt]) tgt = i;
        end
        if (tgt < 0) m_drop[m] = 1;
        else begin
          m_note[m][tgt] = note; m_vel[m][tgt] = vel; m_gate[m][tgt] = 1;
          m_trig[m][tgt] = 1; m_stamp[m][tgt] = now;
        end
      end else begin
        for (int i = 0; i < NV; i++) if (m_gate[m][i] && m_note[m][i] == note) m_gate[m][i] = 0;
      end
    end
  endtask

  task automatic step(bit r, bit pn, bit v, bit on, int note, int vel, int ch);
    exp_t e;
    @(negedge clk_50m);
    now++;
    rst = r;
    ifa.panic = pn; ifa.ev_valid = v; ifa.ev_on = on;
    ifa.ev_note = 7'(note); ifa.ev_vel = 8'(vel); ifa.ev_chan = 4'(ch);
    ifb.panic = pn; ifb.ev_valid = v; ifb.ev_on = on;
    ifb.ev_note = 7'(note); ifb.ev_vel = 8'(vel); ifb.ev_chan = 4'(ch);
    model(0, r, pn, v, on, note, vel, ch);
    model(1, r, pn, v, on, note, vel, ch);
    e = '0;
    for (int i = 0; i < NV; i++) begin
      e.n0[8*i +: 8] = 8'(m_note[0][i]); e.v0[8*i +: 8] = 8'(m_vel[0][i]);
      e.g0[i] = m_gate[0][i];            e.t0[i] = m_trig[0][i];
      e.n1[8*i +: 8] = 8'(m_note[1][i]); e.v1[8*i +: 8] = 8'(m_vel[1][i]);
      e.g1[i] = m_gate[1][i];            e.t1[i] = m_trig[1][i];
    end
    e.d0 = m_drop[0];
    e.d1 = m_drop[1];
    exp_q.push_back(e);
  endtask

  task automatic on_ev(int note, int vel, int ch = 0);
    step(0, 0, 1, 1, note, vel, ch);
  endtask
  task automatic off_ev(int note, int ch = 0);
    step(0, 0, 1, 0, note, 0, ch);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Monitor: one expectation per cycle, compared just after the edge
  always @(posedge clk_50m) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("a_note", ifa.voice_note, e.n0);
      chk("a_vel",  ifa.voice_vel,  e.v0);
      chk("a_gate", 32'(ifa.voice_gate), 32'(e.g0));
      chk("a_trig", 32'(ifa.voice_trig), 32'(e.t0));
      chk("a_drop", 32'(ifa.drop),       32'(e.d0));
      chk("b_note", ifb.voice_note, e.n1);
      chk("b_vel",  ifb.voice_vel,  e.v1);
      chk("b_gate", 32'(ifb.voice_gate), 32'(e.g1));
      chk("b_trig", 32'(ifb.voice_trig), 32'(e.t1));
      chk("b_drop", 32'(ifb.drop),       32'(e.d1));
    end
  end

  initial begin
    ifa.panic = 0; ifa.ev_valid = 0; ifa.ev_on = 0; ifa.ev_note = 0; ifa.ev_vel = 0; ifa.ev_chan = 0;
    ifb.panic = 0; ifb.ev_valid = 0; ifb.ev_on = 0; ifb.ev_note = 0; ifb.ev_vel = 0; ifb.ev_chan = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // First allocation lands on voice 0
    on_ev(60, 90); idle();
    // Fill, then 67 steals the LRU (voice 0) on A and drops on B
    on_ev(62, 70); on_ev(64, 71); on_ev(65, 72); on_ev(67, 73); idle();
    off_ev(60); off_ev(67); idle();
    // Retrigger keeps a single voice
    step(0, 1, 0, 0, 0, 0, 0);
    on_ev(60, 50); on_ev(60, 120); idle();
    // Filtered channel, then velocity-0 note-on acting as note-off on chan 1
    on_ev(70, 100, 5); on_ev(60, 0, 1); idle();
    // All voices held, then one more note-on; then panic with an event alongside
    step(0, 1, 0, 0, 0, 0, 0);
    on_ev(70, 10); on_ev(71, 11); on_ev(72, 12); on_ev(73, 13);
    on_ev(74, 14); idle();
    step(0, 1, 1, 1, 75, 15, 0); idle();
    // Burst with reset in the middle
    on_ev(50, 1); on_ev(51, 2); step(1, 0, 1, 1, 52, 3, 0); on_ev(53, 4); idle();
    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      bit r, pn, v, on;
      int note, vel, ch;
      r    = ($urandom_range(0, 99) == 0);
      pn   = ($urandom_range(0, 29) == 0);
      v    = ($urandom_range(0, 9) < 7);
      on   = ($urandom_range(0, 99) < 65);
      note = 60 + $urandom_range(0, 7);
      vel  = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 255);
      ch   = $urandom_range(0, 5);
      step(r, pn, v, on, note, vel, ch);
    end
    idle(); idle();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk_50m);
    #2;
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
